mvu_apb_csr_responder: RTL and testbench

APB completer on the MVU side of the per-hart CSR bridge. It decodes the address {hart_id, csr_offset[11:0]} issued by the barrel CSR file's APB initiator and holds one small register bank per hart. Each bank can start an MVU job, latch its completion, and raise that hart's `mvu_irq` line. It closes the loop CSR write → APB → MVU start → MVU done → `mvu_irq[h]` → CSR file.

---
 rtl/pito_pkg.sv | 32 +++
 rtl/mvu_apb_csr_responder_bank.sv | 69 ++++++
 rtl/mvu_apb_csr_responder.sv | 125 ++++++++++++
 tb/tb_mvu_apb_csr_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pito_pkg.sv
// Shared types and constants for the MVU-side APB CSR responder.
package pito_pkg;

    typedef enum logic [11:0] {
        CSR_CTRL   = 12'h000,
        CSR_STATUS = 12'h004,
        CSR_ARG0   = 12'h008,
        CSR_ARG1   = 12'h00C
    } mvu_csr_off_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_resp_fsm_e;

    localparam int CTRL_START       = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_DONE_PEND = 1;

    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/mvu_apb_csr_responder_bank.sv
// One hart's MVU CSR bank: job arguments, BUSY/DONE_PEND tracking and the irq flop.
module mvu_csr_bank
    import pito_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acc,
    input  logic        wr,
    input  logic [11:0] off,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    input  logic        mvu_done,
    output logic        mvu_start,
    output logic [31:0] arg0,
    output logic [31:0] arg1,
    output logic        irq,
    output logic [31:0] rdata,
    output logic        err
);

    logic busy, done_pend, irq_en;
    logic is_ctrl, is_status, is_arg0, is_arg1, mapped;
    logic busy_eff, start_req, start_ok, done_set, w1c;

    always_comb begin
        is_ctrl   = (off == CSR_CTRL);
        is_status = (off == CSR_STATUS);
        is_arg0   = (off == CSR_ARG0);
        is_arg1   = (off == CSR_ARG1);
        mapped    = is_ctrl | is_status | is_arg0 | is_arg1;
        // A done pulse in the same cycle frees the engine before START is judged.
        busy_eff  = busy & ~mvu_done;
        start_req = wr & is_ctrl & strb[0] & wdata[CTRL_START];
        start_ok  = acc & start_req & ~busy_eff;
        done_set  = mvu_done & busy;
        w1c       = acc & wr & is_status & strb[0] & wdata[STATUS_DONE_PEND];
        err       = ~mapped | (start_req & busy_eff);
        mvu_start = start_ok;
        rdata     = '0;
        if (is_ctrl)   rdata[CTRL_IRQ_EN] = irq_en;
        if (is_status) begin
            rdata[STATUS_BUSY]      = busy;
            rdata[STATUS_DONE_PEND] = done_pend;
        end
        if (is_arg0)   rdata = arg0;
        if (is_arg1)   rdata = arg1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done_pend <= 1'b0;
            irq_en    <= 1'b0;
            arg0      <= '0;
            arg1      <= '0;
            irq       <= 1'b0;
        end else begin
            if (start_ok)      busy <= 1'b1;
            else if (mvu_done) busy <= 1'b0;
            if (done_set)      done_pend <= 1'b1;
            else if (w1c)      done_pend <= 1'b0;
            if (acc & wr & is_ctrl & strb[0]) irq_en <= wdata[CTRL_IRQ_EN];
            if (acc & wr & is_arg0) arg0 <= strb_merge(arg0, wdata, strb);
            if (acc & wr & is_arg1) arg1 <= strb_merge(arg1, wdata, strb);
            irq <= done_pend & irq_en;
        end
    end

endmodule

// File: rtl/mvu_apb_csr_responder.sv
// APB completer decoding {hart_id, csr_offset} into one mvu_csr_bank per hart.
module mvu_apb_csr_responder
    import pito_pkg::*;
#(
    parameter int NUM_HARTS   = 8,
    parameter int HART_W      = $clog2(NUM_HARTS),
    parameter int WAIT_STATES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                apb_paddr,
    input  logic                       apb_psel,
    input  logic                       apb_penable,
    input  logic                       apb_pwrite,
    input  logic [31:0]                apb_pwdata,
    input  logic [3:0]                 apb_pstrb,
    output logic [31:0]                apb_prdata,
    output logic                       apb_pready,
    output logic                       apb_pslverr,
    output logic [NUM_HARTS-1:0]       mvu_start,
    output logic [NUM_HARTS-1:0][31:0] mvu_arg0,
    output logic [NUM_HARTS-1:0][31:0] mvu_arg1,
    input  logic [NUM_HARTS-1:0]       mvu_done,
    output logic [NUM_HARTS-1:0]       mvu_irq
);

    // The capture cycle itself is the first low-pready cycle, so ACCESS spans WAIT_STATES cycles.
    localparam logic [1:0] WS_LAST = 2'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    apb_resp_fsm_e state_q, state_d;
    logic [1:0]        wait_cnt;
    logic              start_xfer, in_done, in_access, misalign, err;
    logic [11:0]       off_q;
    logic [HART_W-1:0] hart_q;
    logic              hart_err_q, hart_err, wr_q;
    logic [31:0]       wdata_q, rdata_sel;
    logic [3:0]        strb_q;
    logic [NUM_HARTS-1:0]       sel, acc, bank_err;
    logic [NUM_HARTS-1:0][31:0] bank_rdata;
    logic              unused_paddr;

    assign unused_paddr = ^apb_paddr[31:12+HART_W];
    assign start_xfer   = (state_q == IDLE) & apb_psel & apb_penable;
    assign hart_err     = {1'b0, apb_paddr[12 +: HART_W]} >= (HART_W+1)'(NUM_HARTS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (in_access && state_d == ACCESS) ? wait_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_xfer) state_d = (WAIT_STATES == 0) ? DONE : ACCESS;
            ACCESS:  if (wait_cnt == WS_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_access  = (state_q == ACCESS);
        in_done    = (state_q == DONE);
        apb_pready = in_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q      <= '0;
            hart_q     <= '0;
            hart_err_q <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
        end else if (start_xfer) begin
            off_q      <= apb_paddr[11:0];
            hart_q     <= apb_paddr[12 +: HART_W];
            hart_err_q <= hart_err;
            wr_q       <= apb_pwrite;
            wdata_q    <= apb_pwdata;
            strb_q     <= apb_pstrb;
        end
    end

    always_comb begin
        misalign  = (off_q[1:0] != 2'b00);
        rdata_sel = '0;
        err       = hart_err_q | misalign;
        for (int h = 0; h < NUM_HARTS; h++) begin
            sel[h] = (hart_q == HART_W'(h));
            acc[h] = in_done & sel[h] & ~hart_err_q & ~misalign;
            if (sel[h]) begin
                rdata_sel = rdata_sel | bank_rdata[h];
                err       = err | bank_err[h];
            end
        end
        apb_pslverr = in_done & err;
        apb_prdata  = (in_done & ~wr_q & ~err) ? rdata_sel : 32'h0;
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_bank
        mvu_csr_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .acc      (acc[g]),
            .wr       (wr_q),
            .off      (off_q),
            .wdata    (wdata_q),
            .strb     (strb_q),
            .mvu_done (mvu_done[g]),
            .mvu_start(mvu_start[g]),
            .arg0     (mvu_arg0[g]),
            .arg1     (mvu_arg1[g]),
            .irq      (mvu_irq[g]),
            .rdata    (bank_rdata[g]),
            .err      (bank_err[g])
        );
    end

endmodule

// File: tb/tb_mvu_apb_csr_responder.sv
// Scoreboarded random/directed bench for mvu_apb_csr_responder against a transaction-level model.
module tb_mvu_apb_csr_responder;

    localparam int NH = 8;
    localparam int HW = 3;
    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
    logic apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
    logic [3:0] apb_pstrb;
    logic [NH-1:0] mvu_start, mvu_done, mvu_irq;
    logic [NH-1:0][31:0] mvu_arg0, mvu_arg1;

    always #5 clk = ~clk;

    mvu_apb_csr_responder #(.NUM_HARTS(NH), .HART_W(HW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .mvu_start(mvu_start), .mvu_arg0(mvu_arg0), .mvu_arg1(mvu_arg1),
        .mvu_done(mvu_done), .mvu_irq(mvu_irq)
    );

    typedef struct {
        string         name;
        logic [31:0]   rdata;
        logic          err;
        logic [NH-1:0] start;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int fails  = 0;

    // Reference model: architectural register state per hart.
    logic        m_busy[NH], m_pend[NH], m_en[NH];
    logic [31:0] m_a0[NH], m_a1[NH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = cur;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_busy[h] = 0; m_pend[h] = 0; m_en[h] = 0; m_a0[h] = 0; m_a1[h] = 0;
        end
    endtask

    task automatic model_done(input logic [NH-1:0] v, output logic [NH-1:0] set);
        set = '0;
        for (int g = 0; g < NH; g++)
            if (v[g] && m_busy[g]) begin
                m_busy[g] = 0; m_pend[g] = 1; set[g] = 1;
            end
    endtask

    task automatic model_xfer(input string name, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wd, input logic [3:0] st,
                              input logic [NH-1:0] done_v, output exp_t e);
        int h;
        logic [11:0] off;
        logic bad;
        logic [NH-1:0] set;
        h = int'(addr[12 +: HW]);
        off = addr[11:0];
        bad = (addr[1:0] != 0) || !(off inside {12'h000, 12'h004, 12'h008, 12'h00C});
        e.name = name; e.rdata = 0; e.err = bad; e.start = 0;
        if (!bad && !wr)
            case (off)
                12'h000: e.rdata = {30'b0, m_en[h], 1'b0};
                12'h004: e.rdata = {30'b0, m_pend[h], m_busy[h]};
                12'h008: e.rdata = m_a0[h];
                default: e.rdata = m_a1[h];
            endcase
        model_done(done_v, set);
        if (!bad && wr)
            case (off)
                12'h000: if (st[0]) begin
                    m_en[h] = wd[1];
                    if (wd[0]) begin
                        if (m_busy[h]) e.err = 1;
                        else begin m_busy[h] = 1; e.start[h] = 1; end
                    end
                end
                12'h004: if (st[0] && wd[1] && !set[h]) m_pend[h] = 0;
                12'h008: m_a0[h] = merge(m_a0[h], wd, st);
                default: m_a1[h] = merge(m_a1[h], wd, st);
            endcase
    endtask

    // done_v is driven into the DONE cycle to exercise same-cycle conflicts.
    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [NH-1:0] done_v);
        exp_t e;
        bit got = 0;
        model_xfer(name, addr, wr, wd, st, done_v, e);
        sb.push_back(e);
        @(posedge clk); #1;
        apb_psel = 1; apb_penable = 0; apb_paddr = addr; apb_pwrite = wr;
        apb_pwdata = wd; apb_pstrb = st;
        @(posedge clk); #1;
        apb_penable = 1;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(posedge clk); #1;
            if (n == WS + 1) mvu_done = done_v;
            @(negedge clk);
            if (apb_pready) begin
                got = 1;
                chk({name, ".latency"}, n, WS + 1);
            end
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL %s.timeout: pready never rose, required after %0d cycles", name, WS + 1);
            void'(sb.pop_back());
        end
        @(posedge clk); #1;
        apb_psel = 0; apb_penable = 0; mvu_done = '0;
    endtask

    task automatic pulse_done(input logic [NH-1:0] v);
        logic [NH-1:0] set;
        @(posedge clk); #1;
        mvu_done = v;
        model_done(v, set);
        @(posedge clk); #1;
        mvu_done = '0;
    endtask

    task automatic check_state(input string name);
        repeat (2) @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            chk($sformatf("%s.irq%0d", name, h), mvu_irq[h], m_pend[h] & m_en[h]);
            chk($sformatf("%s.arg0_%0d", name, h), mvu_arg0[h], m_a0[h]);
            chk($sformatf("%s.arg1_%0d", name, h), mvu_arg1[h], m_a1[h]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (apb_pready) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL sb_underflow: pready with no transfer outstanding");
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, ".prdata"}, apb_prdata, mon_e.rdata);
                    chk({mon_e.name, ".pslverr"}, apb_pslverr, mon_e.err);
                    chk({mon_e.name, ".start"}, mvu_start, mon_e.start);
                end
            end else begin
                chk("quiet.prdata", apb_prdata, 0);
                chk("quiet.start", mvu_start, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        logic [11:0] off;
        model_reset();
        rst_n = 0; apb_psel = 0; apb_penable = 0; apb_pwrite = 0;
        apb_paddr = 0; apb_pwdata = 0; apb_pstrb = 0; mvu_done = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pready", apb_pready, 0);
        chk("rst.pslverr", apb_pslverr, 0);
        chk("rst.prdata", apb_prdata, 0);
        chk("rst.irq", mvu_irq, 0);
        chk("rst.start", mvu_start, 0);
        chk("rst.arg0_3", mvu_arg0[3], 0);
        rst_n = 1;

        xfer("h3_arg0_w", 32'h3008, 1, 32'hDEADBEEF, 4'hF, '0);
        xfer("h3_arg0_r", 32'h3008, 0, 32'h0, 4'h0, '0);

        xfer("h5_ctrl_w", 32'h5000, 1, 32'h3, 4'h1, '0);
        xfer("h5_stat_r", 32'h5004, 0, 32'h0, 4'h0, '0);
        @(posedge clk); #1;
        mvu_done = 8'h20;
        @(posedge clk); #1;
        mvu_done = '0;
        m_busy[5] = 0; m_pend[5] = 1;
        chk("h5_irq_t1", mvu_irq[5], 0);
        @(posedge clk); #1;
        chk("h5_irq_t2", mvu_irq[5], 1);
        xfer("h5_stat_r2", 32'h5004, 0, 32'h0, 4'h0, '0);
        xfer("h5_w1c", 32'h5004, 1, 32'h2, 4'h1, '0);
        check_state("h5_after_w1c");

        xfer("h2_start", 32'h2000, 1, 32'h1, 4'h1, '0);
        xfer("h2_start_busy", 32'h2000, 1, 32'h3, 4'h1, '0);
        xfer("h2_ctrl_r", 32'h2000, 0, 32'h0, 4'h0, '0);

        xfer("err_off10", 32'h3010, 1, 32'h1234, 4'hF, '0);
        xfer("err_misalign", 32'h3009, 1, 32'h5678, 4'hF, '0);
        xfer("err_off10_r", 32'h3010, 0, 32'h0, 4'h0, '0);
        xfer("upper_ignored", 32'hABC0_3008, 0, 32'h0, 4'h0, '0);
        check_state("after_errs");

        xfer("h1_arg1_strb", 32'h100C, 1, 32'hAABBCCDD, 4'h2, '0);
        xfer("h1_arg1_r", 32'h100C, 0, 32'h0, 4'h0, '0);
        xfer("h2_ctrl_nostrb", 32'h2000, 1, 32'h3, 4'h2, '0);

        xfer("h2_start_vs_done", 32'h2000, 1, 32'h1, 4'h1, 8'h04);
        xfer("h2_w1c_vs_done", 32'h2004, 1, 32'h2, 4'h1, 8'h04);
        xfer("h2_stat_r", 32'h2004, 0, 32'h0, 4'h0, '0);
        pulse_done(8'h80);
        check_state("after_conflicts");

        // Reset lands in ACCESS of an ARG0 write; nothing may stick.
        @(posedge clk); #1;
        apb_psel = 1; apb_penable = 0; apb_paddr = 32'h6008; apb_pwrite = 1;
        apb_pwdata = 32'hCAFEF00D; apb_pstrb = 4'hF;
        @(posedge clk); #1;
        apb_penable = 1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rst_mid.pready", apb_pready, 0);
        model_reset();
        @(posedge clk); #1;
        apb_psel = 0; apb_penable = 0;
        rst_n = 1;
        chk("rst_mid.arg0_6", mvu_arg0[6], 0);
        xfer("rst_mid_r", 32'h6008, 0, 32'h0, 4'h0, '0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    off = 12'h000;
                2:       off = 12'h004;
                3:       off = 12'h008;
                4:       off = 12'h00C;
                5:       off = 12'(4 * $urandom_range(4, 1023));
                default: off = 12'($urandom_range(0, 15));
            endcase
            a = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, NH - 1)) << 12) | 32'(off);
            d = $urandom;
            if ($urandom_range(0, 3) == 0) pulse_done(NH'($urandom));
            xfer($sformatf("rnd%0d", i), a, 1'($urandom), d, 4'($urandom),
                 ($urandom_range(0, 4) == 0) ? NH'($urandom) : '0);
            if (i % 25 == 24) check_state($sformatf("rnd_state%0d", i));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
